// File: rtl/alu_operand_sequencer.sv
// Multi-cycle execute controller wrapped around a 16-bit ALU: fetches two operands
// through a single one-cycle-latency register-file read port, executes, then writes back.
module alu_operand_sequencer #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_operator,
  input  logic [RA_W-1:0]  in_dst,
  input  logic [RA_W-1:0]  in_src,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  output logic [RA_W-1:0]  rf_addr,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [WIDTH-1:0] alu_value1,
  output logic [WIDTH-1:0] alu_value2,
  output logic [3:0]       alu_operator,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic [3:0]       flags,
  output logic             done
);

  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_A   = 3'd1,
    S_RD_B   = 3'd2,
    S_RD_LAT = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       opc_q;
  logic [RA_W-1:0]  dst_q;
  logic [RA_W-1:0]  src_q;
  logic             use_imm_q;
  logic [WIDTH-1:0] imm_q;
  logic [RA_W-1:0]  rf_addr_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [3:0]       alu_op_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       flg_q;
  logic [3:0]       flags_q;
  logic             ready_q;
  logic             done_q;
  logic             we_q;
  logic [RA_W-1:0]  waddr_q;

  // Next-state selection for the execute sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_RD_A;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_A:   state_d = S_RD_B;
      S_RD_B: begin
        if (use_imm_q) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_RD_LAT;
        end
      end
      S_RD_LAT: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, operand, result and output registers; outputs are set up one edge ahead of their state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opc_q     <= 4'd0;
      dst_q     <= {RA_W{1'b0}};
      src_q     <= {RA_W{1'b0}};
      use_imm_q <= 1'b0;
      imm_q     <= {WIDTH{1'b0}};
      rf_addr_q <= {RA_W{1'b0}};
      op_a_q    <= {WIDTH{1'b0}};
      op_b_q    <= {WIDTH{1'b0}};
      alu_op_q  <= 4'd0;
      res_q     <= {WIDTH{1'b0}};
      flg_q     <= 4'd0;
      flags_q   <= 4'd0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= {RA_W{1'b0}};
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            opc_q     <= in_operator;
            dst_q     <= in_dst;
            src_q     <= in_src;
            use_imm_q <= in_use_imm;
            imm_q     <= in_imm;
            rf_addr_q <= in_dst;
            ready_q   <= 1'b0;
          end
        end
        S_RD_A: begin
          rf_addr_q <= src_q;
        end
        S_RD_B: begin
          // Read data for dst arrives now, one cycle after it was addressed.
          op_a_q   <= rf_rdata;
          alu_op_q <= opc_q;
          if (use_imm_q) begin
            op_b_q <= imm_q;
          end
        end
        S_RD_LAT: begin
          op_b_q <= rf_rdata;
        end
        S_EXEC: begin
          res_q   <= alu_result;
          flg_q   <= alu_flags;
          done_q  <= 1'b1;
          we_q    <= (opc_q != OP_CMP);
          waddr_q <= dst_q;
        end
        S_WB: begin
          done_q  <= 1'b0;
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          if (opc_q != OP_MOV) begin
            flags_q <= flg_q;
          end
        end
        default: begin
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Reset gates the handshake and write strobes immediately so nothing escapes in the reset cycle.
  assign in_ready     = ready_q & ~rst;
  assign done         = done_q & ~rst;
  assign rf_we        = we_q & ~rst;
  assign rf_addr      = rf_addr_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = res_q;
  assign alu_value1   = op_a_q;
  assign alu_value2   = op_b_q;
  assign alu_operator = alu_op_q;
  assign flags        = flags_q;

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Multi-cycle execute controller that sits directly upstream and downstream of the 16-bit ALU.
- Accepts one decoded ALU instruction at a time and fetches both operands through the register file's single read port.
- Drives the ALU's value1/value2/operator inputs from registered operands, captures the ALU result and flags, then performs register writeback and updates the architectural flag register.

Parameters:
- WIDTH, 16, data width of operands, result and register-file data.
- RA_W, 3, register-file address width (8 registers).

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  sequencer can accept an instruction this cycle.
- in_operator  input  4  ALU opcode, shared opcode encoding (ADD, SUB, ADC, SBC, AND, OR, XOR, CMP, MOV).
- in_dst  input  RA_W  destination register; also the source of operand A.
- in_src  input  RA_W  register supplying operand B.
- in_use_imm  input  1  operand B taken from in_imm instead of in_src.
- in_imm  input  WIDTH  immediate operand.
- rf_addr  output  RA_W  register-file read address; data returns exactly one cycle later.
- rf_rdata  input  WIDTH  register-file read data.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  RA_W  write address.
- rf_wdata  output  WIDTH  write data.
- alu_value1  output  WIDTH  ALU operand 1 (registered operand A).
- alu_value2  output  WIDTH  ALU operand 2 (registered operand B).
- alu_operator  output  4  ALU opcode (registered).
- alu_result  input  WIDTH  combinational ALU result.
- alu_flags  input  4  combinational ALU flags {carry, overflow, zero, negative}.
- flags  output  4  architectural flag register.
- done  output  1  one-cycle pulse in the writeback cycle.

Behaviour:
- Reset values: all outputs 0 except in_ready = 0 during reset and 1 in the first cycle after reset. FSM in IDLE. Operand, opcode and result registers cleared to 0.
- FSM states and transitions:
  - IDLE: in_ready = 1. When in_valid is high, latch operator/dst/src/use_imm/imm and go to RD_A.
  - RD_A: rf_addr = dst. Next state RD_B.
  - RD_B: rf_addr = src; op_a <= rf_rdata; if use_imm, op_b <= imm and go to EXEC, else go to RD_LAT.
  - RD_LAT: op_b <= rf_rdata. Next state EXEC.
  - EXEC: alu_value1/value2/operator driven from registers; res <= alu_result; flg <= alu_flags. Next state WB.
  - WB: done = 1; rf_we = 1 unless operator is CMP; rf_waddr = dst; rf_wdata = res; flags <= flg unless operator is MOV. Next state IDLE.
- in_ready is low in every state except IDLE; in_valid is ignored outside IDLE.
- rf_addr holds its last value in IDLE, EXEC and WB.
- alu_value1/alu_value2/alu_operator are stable from EXEC entry until the next instruction's RD_B/RD_LAT updates them.
- Latency, counted from the accept edge: register-register ops write back in the 5th cycle (RD_A, RD_B, RD_LAT, EXEC, WB). Immediate ops write back in the 4th cycle. Throughput is one instruction per 6 cycles (register) or 5 cycles (immediate), including the IDLE cycle.
- dst == src is legal; the register is read twice and gives the same value.
- Undefined opcodes are passed through: the ALU returns 0, which is written back and the flags are updated.
- Flags are only changed in WB. CMP updates flags but does not write. MOV writes but does not change flags.
- Reset in any state returns the FSM to IDLE the next cycle. rf_we and done are forced to 0 in the reset cycle; the in-flight instruction is discarded with no write; flags clear to 0.

Test Plan:
1. Assert rst for 2 cycles with in_valid = 1 -> in_ready = 0, rf_we = 0, flags = 0; in_ready = 1 in the cycle after rst drops; no instruction accepted during reset.
2. r1 = 0x1234, r2 = 0x0F0F, ADD dst = 1 src = 2 -> rf_addr = 1 then 2; alu_value1 = 0x1234, alu_value2 = 0x0F0F in EXEC; rf_we with rf_waddr = 1, rf_wdata = 0x2143 in the 5th cycle after accept; done pulses once; flags equal the ALU flags sampled in EXEC.
3. SUB dst = 3 (0x0005), in_use_imm = 1, in_imm = 0x0007 -> rf_wdata = 0xFFFE to r3 in the 4th cycle after accept; no RD_LAT cycle; flags carry = 1, negative = 1.
4. CMP dst = 1 (0x00FF) src = 2 (0x00FF) -> rf_we stays 0 throughout; done pulses; flags updated from the ALU. Then MOV dst = 4 imm 0x8000 -> r4 = 0x8000, flags unchanged from the CMP.
5. Back-to-back: in_valid held high with two ADDs -> second accepted only in the IDLE cycle after the first WB (accepts exactly 6 cycles apart); second instruction reads the register value written by the first.
6. Assert rst during EXEC of an ADD to r5 -> no write to r5, done stays 0, flags = 0, in_ready = 1 the cycle after rst deasserts.
